// File: rtl/sbc_acia.sv
// sbc_acia: byte-wide serial ACIA with RX/TX FIFOs, programmable baud divisor,
// 16x oversampled receiver, modem control lines and a single active-low interrupt.
module sbc_acia #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd0
) (
    input  logic       fst_clk,
    input  logic       res_n,
    input  logic       cs,
    input  logic       rw,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq_n,
    input  logic       acia_rx,
    input  logic       acia_cts_n,
    input  logic       acia_dcd_n,
    input  logic       acia_dsr_n,
    output logic       acia_tx,
    output logic       acia_rts_n,
    output logic       acia_dtr_n
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] RTS_CNT  = CW'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} frame_state_t;

    // synchronisers and edge history
    logic r_rx_s1, r_rx_s2, r_rx_d;
    logic r_cts_s1, r_cts_s2;
    logic r_dcd_s1, r_dcd_s2;
    logic r_dsr_s1, r_dsr_s2;

    // programmable registers and sticky flags
    logic [4:0]  r_cmd;
    logic [15:0] r_div;
    logic [15:0] r_baud_cnt;
    logic        r_ovr, r_fe;

    // RX FIFO
    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rx_wp, r_rx_rp;
    logic [CW-1:0] r_rx_cnt;

    // TX FIFO
    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_tx_wp, r_tx_rp;
    logic [CW-1:0] r_tx_cnt;

    // RX / TX engines
    frame_state_t r_rx_state, r_tx_state;
    logic [3:0]   r_rx_tcnt, r_tx_tcnt;
    logic [2:0]   r_rx_bit, r_tx_bit;
    logic [7:0]   r_rx_shift, r_tx_shift;
    logic         r_tx;
    logic         r_irq_n, r_rts_n;

    logic       w_tick;
    logic       w_rd, w_wr;
    logic       w_rx_ne, w_rx_full, w_tx_empty, w_tx_full, w_tx_idle;
    logic       w_rx_pop, w_tx_push, w_tx_start;
    logic       w_rx_stop_now, w_rx_push, w_set_ovr, w_set_fe;
    logic       w_irq;
    logic [7:0] w_status;

    assign w_rd       = cs & rw;
    assign w_wr       = cs & ~rw;
    assign w_rx_ne    = (r_rx_cnt != '0);
    assign w_rx_full  = (r_rx_cnt == FULL_CNT);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == FULL_CNT);
    assign w_tx_idle  = (r_tx_state == ST_IDLE) & w_tx_empty;

    assign w_rx_pop   = w_rd & (addr == 3'd0) & w_rx_ne;
    assign w_tx_push  = w_wr & (addr == 3'd0) & ~w_tx_full;
    assign w_tx_start = (r_tx_state == ST_IDLE) & ~w_tx_empty & (~r_cmd[4] | ~r_cts_s2);

    // Stop-bit sample: a same-edge bus pop frees a slot before the push lands.
    assign w_rx_stop_now = (r_rx_state == ST_STOP) & w_tick & (r_rx_tcnt == 4'd15);
    assign w_rx_push     = w_rx_stop_now & r_rx_s2 & (~w_rx_full | w_rx_pop);
    assign w_set_ovr     = w_rx_stop_now & r_rx_s2 & w_rx_full & ~w_rx_pop;
    assign w_set_fe      = w_rx_stop_now & ~r_rx_s2;

    assign w_irq    = (r_cmd[1] & (w_rx_ne | r_ovr | r_fe)) | (r_cmd[2] & w_tx_empty);
    assign w_status = {w_irq, r_dsr_s2, r_dcd_s2, w_tx_idle, r_fe, r_ovr, ~w_tx_full, w_rx_ne};
    assign w_tick   = (r_baud_cnt == 16'd0);

    assign acia_tx    = r_tx;
    assign acia_rts_n = r_rts_n;
    assign acia_dtr_n = ~r_cmd[0];
    assign irq_n      = r_irq_n;

    // Two-flop synchronisers for all asynchronous inputs, plus RX edge history
    always_ff @(posedge fst_clk or negedge res_n) begin
        if (!res_n) begin
            r_rx_s1  <= 1'b1; r_rx_s2  <= 1'b1; r_rx_d <= 1'b1;
            r_cts_s1 <= 1'b1; r_cts_s2 <= 1'b1;
            r_dcd_s1 <= 1'b1; r_dcd_s2 <= 1'b1;
            r_dsr_s1 <= 1'b1; r_dsr_s2 <= 1'b1;
        end else begin
            r_rx_s1  <= acia_rx;    r_rx_s2  <= r_rx_s1; r_rx_d <= r_rx_s2;
            r_cts_s1 <= acia_cts_n; r_cts_s2 <= r_cts_s1;
            r_dcd_s1 <= acia_dcd_n; r_dcd_s2 <= r_dcd_s1;
            r_dsr_s1 <= acia_dsr_n; r_dsr_s2 <= r_dsr_s1;
        end
    end

    // Baud tick generator; a new divisor is picked up at the next reload
    always_ff @(posedge fst_clk or negedge res_n) begin
        if (!res_n) r_baud_cnt <= 16'd0;
        else        r_baud_cnt <= w_tick ? r_div : (r_baud_cnt - 16'd1);
    end

    // Command/divisor registers and sticky error flags (a new error wins over a clear)
    always_ff @(posedge fst_clk or negedge res_n) begin
        if (!res_n) begin
            r_cmd <= 5'd0;
            r_div <= DIV_RESET;
            r_ovr <= 1'b0;
            r_fe  <= 1'b0;
        end else begin
            if (w_wr) begin
                case (addr)
                    3'd1: begin r_ovr <= 1'b0; r_fe <= 1'b0; end
                    3'd2: r_cmd <= din[4:0];
                    3'd3: r_div[7:0] <= din;
                    3'd4: r_div[15:8] <= din;
                    default: ;
                endcase
            end
            if (w_set_ovr) r_ovr <= 1'b1;
            if (w_set_fe)  r_fe  <= 1'b1;
        end
    end

    // RX FIFO storage
    always_ff @(posedge fst_clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge fst_clk or negedge res_n) begin
        if (!res_n) begin
            r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    // TX FIFO storage
    always_ff @(posedge fst_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= din;
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge fst_clk or negedge res_n) begin
        if (!res_n) begin
            r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
        end else begin
            if (w_tx_push)  r_tx_wp <= r_tx_wp + AW'(1);
            if (w_tx_start) r_tx_rp <= r_tx_rp + AW'(1);
            case ({w_tx_push, w_tx_start})
                2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    // Receiver: start validated at mid-bit (tick 8), data and stop sampled 16 ticks apart
    always_ff @(posedge fst_clk or negedge res_n) begin
        if (!res_n) begin
            r_rx_state <= ST_IDLE;
            r_rx_tcnt  <= 4'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'd0;
        end else begin
            case (r_rx_state)
                ST_IDLE: begin
                    if (r_rx_d & ~r_rx_s2) begin
                        r_rx_state <= ST_START;
                        r_rx_tcnt  <= 4'd0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == 4'd7) begin
                            r_rx_tcnt  <= 4'd0;
                            r_rx_bit   <= 3'd0;
                            r_rx_state <= r_rx_s2 ? ST_IDLE : ST_DATA;
                        end else begin
                            r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == 4'd15) begin
                            r_rx_tcnt  <= 4'd0;
                            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                            if (r_rx_bit == 3'd7) r_rx_state <= ST_STOP;
                            else                  r_rx_bit   <= r_rx_bit + 3'd1;
                        end else begin
                            r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        end
                    end
                end
                default: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == 4'd15) r_rx_state <= ST_IDLE;
                        else                    r_rx_tcnt  <= r_rx_tcnt + 4'd1;
                    end
                end
            endcase
        end
    end

    // Transmitter: 16 ticks per bit, LSB first; line held high outside START/DATA
    always_ff @(posedge fst_clk or negedge res_n) begin
        if (!res_n) begin
            r_tx_state <= ST_IDLE;
            r_tx_tcnt  <= 4'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_tx_start) begin
                        r_tx_state <= ST_START;
                        r_tx_shift <= r_tx_mem[r_tx_rp];
                        r_tx_tcnt  <= 4'd0;
                        r_tx       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_tx_tcnt == 4'd15) begin
                            r_tx_state <= ST_DATA;
                            r_tx_tcnt  <= 4'd0;
                            r_tx_bit   <= 3'd0;
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        end else begin
                            r_tx_tcnt <= r_tx_tcnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_tx_tcnt == 4'd15) begin
                            r_tx_tcnt <= 4'd0;
                            if (r_tx_bit == 3'd7) begin
                                r_tx_state <= ST_STOP;
                                r_tx       <= 1'b1;
                            end else begin
                                r_tx_bit   <= r_tx_bit + 3'd1;
                                r_tx       <= r_tx_shift[0];
                                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            end
                        end else begin
                            r_tx_tcnt <= r_tx_tcnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_tx <= 1'b1;
                    if (w_tick) begin
                        if (r_tx_tcnt == 4'd15) r_tx_state <= ST_IDLE;
                        else                    r_tx_tcnt  <= r_tx_tcnt + 4'd1;
                    end
                end
            endcase
        end
    end

    // Registered interrupt and request-to-send outputs
    always_ff @(posedge fst_clk or negedge res_n) begin
        if (!res_n) begin
            r_irq_n <= 1'b1;
            r_rts_n <= 1'b1;
        end else begin
            r_irq_n <= ~w_irq;
            r_rts_n <= r_cmd[4] ? (r_rx_cnt >= RTS_CNT) : ~r_cmd[3];
        end
    end

    // Read data mux; zero whenever no read access is in progress
    always_comb begin
        dout = 8'h00;
        if (w_rd) begin
            case (addr)
                3'd0:    dout = w_rx_ne ? r_rx_mem[r_rx_rp] : 8'h00;
                3'd1:    dout = w_status;
                3'd2:    dout = {3'b000, r_cmd};
                3'd3:    dout = r_div[7:0];
                3'd4:    dout = r_div[15:8];
                default: dout = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_sbc_acia.sv
// tb_sbc_acia: scoreboard bench for sbc_acia. Bus reads and serial TX frames are
// checked by independent monitors against expectations queued by the stimulus.
module tb_sbc_acia;

    localparam int unsigned DEPTH = 8;

    logic       fst_clk;
    logic       res_n, cs, rw;
    logic [2:0] addr;
    logic [7:0] din, dout;
    logic       irq_n, acia_rx, acia_cts_n, acia_dcd_n, acia_dsr_n;
    logic       acia_tx, acia_rts_n, acia_dtr_n;

    sbc_acia #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd0)) dut (
        .fst_clk(fst_clk), .res_n(res_n), .cs(cs), .rw(rw), .addr(addr),
        .din(din), .dout(dout), .irq_n(irq_n), .acia_rx(acia_rx),
        .acia_cts_n(acia_cts_n), .acia_dcd_n(acia_dcd_n), .acia_dsr_n(acia_dsr_n),
        .acia_tx(acia_tx), .acia_rts_n(acia_rts_n), .acia_dtr_n(acia_dtr_n)
    );

    initial fst_clk = 1'b0;
    always #5 fst_clk = ~fst_clk;

    int checks = 0;
    int errors = 0;

    // scoreboard queues
    logic [7:0] rd_exp[$];
    string      rd_name[$];
    logic [7:0] tx_q[$];

    // reference model state
    logic [7:0]  m_rxq[$];
    logic        m_ovr, m_fe, m_dcd, m_dsr;
    logic [4:0]  m_cmd;
    logic [15:0] m_div;
    int          m_tx_pending;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, got, want, $time);
        end
    endtask

    function automatic logic m_irq();
        return (m_cmd[1] && (m_rxq.size() != 0 || m_ovr || m_fe)) ||
               (m_cmd[2] && m_tx_pending == 0);
    endfunction

    function automatic logic m_rts_n();
        return m_cmd[4] ? (m_rxq.size() >= int'(DEPTH) - 2) : !m_cmd[3];
    endfunction

    function automatic logic [7:0] m_status();
        return {m_irq(), m_dsr, m_dcd, m_tx_pending == 0, m_fe, m_ovr,
                m_tx_pending < int'(DEPTH), m_rxq.size() != 0};
    endfunction

    function automatic void model_reset();
        m_rxq.delete();
        m_ovr = 1'b0; m_fe = 1'b0; m_cmd = 5'd0; m_div = 16'd0; m_tx_pending = 0;
    endfunction

    task automatic clks(input int n);
        repeat (n) @(posedge fst_clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(posedge fst_clk); #1;
        cs = 1'b1; rw = 1'b0; addr = a; din = d;
        @(posedge fst_clk); #1;
        cs = 1'b0; rw = 1'b1; addr = 3'd0; din = 8'h00;
        case (a)
            3'd1: begin m_ovr = 1'b0; m_fe = 1'b0; end
            3'd2: m_cmd = d[4:0];
            3'd3: m_div[7:0] = d;
            3'd4: m_div[15:8] = d;
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [7:0] want, input string nm);
        @(posedge fst_clk); #1;
        cs = 1'b1; rw = 1'b1; addr = a;
        rd_exp.push_back(want); rd_name.push_back(nm);
        @(posedge fst_clk); #1;
        cs = 1'b0; addr = 3'd0;
    endtask

    task automatic read_data();
        logic [7:0] want;
        want = (m_rxq.size() != 0) ? m_rxq.pop_front() : 8'h00;
        bus_read(3'd0, want, "rx_data");
    endtask

    task automatic read_status();
        bus_read(3'd1, m_status(), "status");
    endtask

    task automatic tx_write(input logic [7:0] d);
        bus_write(3'd0, d);
        if (m_tx_pending < int'(DEPTH)) begin
            tx_q.push_back(d);
            m_tx_pending++;
        end
    endtask

    task automatic hold_rx(input logic v);
        #1 acia_rx = v;
        repeat (16) @(posedge fst_clk);
    endtask

    // One serial frame at 16 clocks per bit; the model is updated once the frame is over.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        @(posedge fst_clk);
        hold_rx(1'b0);
        for (int i = 0; i < 8; i++) hold_rx(b[i]);
        #1 acia_rx = stop_ok;
        check("irq_n_before_stop", irq_n, !m_irq());
        repeat (16) @(posedge fst_clk);
        hold_rx(1'b1);
        clks(8);
        if (!stop_ok)                          m_fe = 1'b1;
        else if (m_rxq.size() < int'(DEPTH))   m_rxq.push_back(b);
        else                                   m_ovr = 1'b1;
        #1;
        check("irq_n_after_frame", irq_n, !m_irq());
        check("rts_n_after_frame", acia_rts_n, m_rts_n());
    endtask

    task automatic wait_tx_drain();
        int n;
        n = 0;
        while (tx_q.size() != 0 && n < 20000) begin
            @(posedge fst_clk);
            n++;
        end
        check("tx_drain_timeout", tx_q.size() == 0, 1'b1);
        tx_q.delete();
        clks(180);
        m_tx_pending = 0;
    endtask

    task automatic check_line_high(input string nm, input int n);
        logic ok;
        ok = 1'b1;
        repeat (n) begin
            @(negedge fst_clk);
            if (acia_tx !== 1'b1) ok = 1'b0;
        end
        check(nm, ok, 1'b1);
    endtask

    // Bus read monitor: compares dout against the oldest queued expectation
    initial begin
        forever begin
            @(negedge fst_clk);
            if (res_n && cs && rw) begin
                if (rd_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL read_unexpected: got=%h expected=none", dout);
                end else begin
                    check(rd_name.pop_front(), 32'(dout), 32'(rd_exp.pop_front()));
                end
            end
        end
    end

    // TX line monitor: decodes each frame, checking every clock of every bit
    initial begin
        logic [7:0] want, got;
        logic [9:0] pat;
        logic       stable, aborted;
        forever begin
            @(negedge fst_clk);
            if (res_n && acia_tx === 1'b0) begin
                if (tx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected_frame: got=frame expected=idle at %0t", $time);
                    want = 8'h00;
                end else begin
                    want = tx_q.pop_front();
                end
                pat = {1'b1, want, 1'b0};
                stable = 1'b1; aborted = 1'b0; got = 8'h00;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int s = 0; s < 16 && !aborted; s++) begin
                        if (b != 0 || s != 0) @(negedge fst_clk);
                        if (!res_n) aborted = 1'b1;
                        else begin
                            if (acia_tx !== pat[b]) stable = 1'b0;
                            if (s == 8 && b >= 1 && b <= 8) got[b-1] = acia_tx;
                        end
                    end
                end
                if (!aborted) check("tx_frame", {23'd0, stable, got}, {23'd0, 1'b1, want});
            end
        end
    end

    // Global watchdog
    initial begin
        #20000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v, r1, r2;
        logic       found;
        res_n = 1'b0; cs = 1'b0; rw = 1'b1; addr = 3'd0; din = 8'h00;
        acia_rx = 1'b1; acia_cts_n = 1'b0; acia_dcd_n = 1'b1; acia_dsr_n = 1'b1;
        model_reset();
        m_dcd = 1'b1; m_dsr = 1'b1;

        // outputs while held in reset
        clks(3); #1;
        check("rst_tx", acia_tx, 1'b1);
        check("rst_rts_n", acia_rts_n, 1'b1);
        check("rst_dtr_n", acia_dtr_n, 1'b1);
        check("rst_irq_n", irq_n, 1'b1);
        check("rst_dout", dout, 8'h00);
        res_n = 1'b1;
        clks(4);
        read_status();
        read_data();

        // command register, modem lines and derived outputs
        for (int i = 0; i < 4; i++) begin
            v = 8'($urandom);
            m_dcd = 1'($urandom); m_dsr = 1'($urandom);
            acia_dcd_n = m_dcd; acia_dsr_n = m_dsr;
            bus_write(3'd2, v);
            bus_read(3'd2, {3'b000, v[4:0]}, "cmd_readback");
            clks(3); #1;
            check("dtr_n", acia_dtr_n, !m_cmd[0]);
            check("rts_n", acia_rts_n, m_rts_n());
            check("irq_n", irq_n, !m_irq());
            read_status();
        end
        bus_write(3'd2, 8'h00);

        // transmit 0x55, then random pairs
        tx_write(8'h55);
        wait_tx_drain();
        read_status();
        for (int i = 0; i < 3; i++) begin
            tx_write(8'($urandom));
            tx_write(8'($urandom));
            wait_tx_drain();
        end
        read_status();

        // receive 0xA3, then random frames
        send_frame(8'hA3, 1'b1);
        read_status();
        read_data();
        read_data();
        read_status();
        for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
        read_status();
        for (int i = 0; i < 4; i++) read_data();

        // framing error with rx interrupt enabled
        bus_write(3'd2, 8'h02);
        send_frame(8'($urandom), 1'b0);
        read_status();
        read_data();
        bus_write(3'd1, 8'h00);
        clks(2); #1;
        check("irq_n_after_clear", irq_n, !m_irq());
        read_status();
        send_frame(8'($urandom), 1'b1);
        read_data();
        bus_write(3'd2, 8'h00);

        // one-clock glitch on rx
        @(posedge fst_clk); #1 acia_rx = 1'b0;
        @(posedge fst_clk); #1 acia_rx = 1'b1;
        clks(40);
        read_status();

        // overrun: one frame more than the FIFO holds
        for (int i = 0; i < int'(DEPTH) + 1; i++) send_frame(8'($urandom), 1'b1);
        read_status();
        for (int i = 0; i < int'(DEPTH) + 1; i++) read_data();
        read_status();
        bus_write(3'd1, 8'h00);
        read_status();

        // auto flow control: rts follows RX occupancy
        bus_write(3'd2, 8'h10);
        clks(3); #1;
        check("afc_rts_n_empty", acia_rts_n, m_rts_n());
        for (int i = 0; i < int'(DEPTH) - 2; i++) send_frame(8'($urandom), 1'b1);
        for (int i = 0; i < int'(DEPTH) - 2; i++) read_data();
        clks(3); #1;
        check("afc_rts_n_drained", acia_rts_n, m_rts_n());
        bus_write(3'd2, 8'h08);
        clks(3); #1;
        check("manual_rts_n", acia_rts_n, m_rts_n());

        // auto flow control: CTS gating of the transmitter, TX FIFO full drop
        bus_write(3'd2, 8'h10);
        #1 acia_cts_n = 1'b1;
        clks(4);
        tx_write(8'h12);
        check_line_high("cts_blocks_tx", 40);
        for (int i = 0; i < int'(DEPTH); i++) tx_write(8'($urandom));
        read_status();
        @(posedge fst_clk); #1 acia_cts_n = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge fst_clk);
            if (acia_tx === 1'b0) found = 1'b1;
        end
        check("cts_start_latency", found, 1'b1);
        wait_tx_drain();
        read_status();
        bus_write(3'd2, 8'h00);

        // reset in the middle of a transmit frame
        tx_write(8'($urandom));
        tx_write(8'($urandom));
        clks(60);
        #1 res_n = 1'b0;
        #1;
        check("midtx_reset_tx", acia_tx, 1'b1);
        check("midtx_reset_irq_n", irq_n, 1'b1);
        tx_q.delete();
        model_reset();
        clks(3);
        #1 res_n = 1'b1;
        clks(3);
        check_line_high("no_tx_after_reset", 200);
        read_status();

        // divisor registers and unused addresses
        r1 = 8'($urandom); r2 = 8'($urandom);
        bus_write(3'd3, r1);
        bus_write(3'd4, r2);
        bus_read(3'd3, m_div[7:0], "div_lo");
        bus_read(3'd4, m_div[15:8], "div_hi");
        bus_write(3'd5, 8'($urandom));
        for (int a = 5; a < 8; a++) bus_read(3'(a), 8'h00, "unused_addr");
        read_status();
        @(posedge fst_clk); #1 res_n = 1'b0;
        model_reset();
        clks(2); #1 res_n = 1'b1;
        clks(3);
        bus_read(3'd3, 8'h00, "div_lo_reset");
        bus_read(3'd4, 8'h00, "div_hi_reset");

        clks(4);
        check("read_queue_empty", rd_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
